uart_cmd_rx: RTL and testbench

Serial command front-end for the virtual-input path. It receives 8N1 UART bytes from the host PC and decodes toggle and LED-value commands. It drives the downstream toggle decoder's `number`/`control`/`value` inputs, guaranteeing `number` is stable before and during every `control` rising edge.

---
 rtl/uart_cmd_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_cmd_rx                                                              |
// | 8N1 UART command receiver driving the toggle decoder's number/control/   |
// | value inputs. Define UART_CMD_PARITY_EN for 8E1 frames.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_cmd_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int CTRL_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [3:0] number,
    output logic       control,
    output logic       value,
    output logic       frame_error,
    output logic       cmd_error,
    output logic       busy
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] C_BAUD_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_BAUD_ONE  = CNT_W'(1);
    localparam logic [7:0]       C_HOLD_LAST = 8'(CTRL_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        C_IDLE, C_SETUP, C_HIGH, C_LOW
    } seq_state_t;

    logic             rx_meta_q;
    logic             rxs_q;
    rx_state_t        rx_state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shreg_q;
    logic [7:0]       byte_q;
    logic             byte_vld_q;
    logic             ferr_q;
    seq_state_t       seq_q;
    logic [7:0]       hold_cnt_q;
    logic [3:0]       number_q;
    logic             control_q;
    logic             value_q;
    logic             w_par_ok;

`ifdef UART_CMD_PARITY_EN
    logic par_ok_q;
    assign w_par_ok = par_ok_q;
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_CMD_PARITY_EN
            par_ok_q   <= 1'b0;
`endif
        end else begin
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
            baud_cnt_q <= baud_cnt_q + C_BAUD_ONE;
            case (rx_state_q)
                S_IDLE: begin
                    baud_cnt_q <= '0;
                    if (!rxs_q) rx_state_q <= S_START;
                end
                S_START: begin
                    if (baud_cnt_q == C_BAUD_HALF) begin
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        rx_state_q <= rxs_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_cnt_q == C_BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        shreg_q    <= {rxs_q, shreg_q[7:1]};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
                            rx_state_q <= S_PARITY;
`else
                            rx_state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_CMD_PARITY_EN
                S_PARITY: begin
                    if (baud_cnt_q == C_BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        par_ok_q   <= ((^shreg_q) == rxs_q);
                        rx_state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // A low stop bit reports a single frame_error even if parity also failed
                    if (baud_cnt_q == C_BAUD_LAST) begin
                        if (rxs_q) begin
                            rx_state_q <= S_IDLE;
                            byte_q     <= shreg_q;
                            byte_vld_q <= w_par_ok;
                            ferr_q     <= !w_par_ok;
                        end else begin
                            rx_state_q <= S_WAIT_IDLE;
                            ferr_q     <= 1'b1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxs_q) rx_state_q <= S_IDLE;
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    logic w_is_toggle;
    logic w_is_value;
    logic w_accept;

    assign w_is_toggle = byte_vld_q && (byte_q[7:4] == 4'h5);
    assign w_is_value  = byte_vld_q && (byte_q[7:4] == 4'h6);
    assign w_accept    = w_is_toggle && (seq_q == C_IDLE);

    // number only moves on C_SETUP entry, so it is settled a full cycle before control rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_q      <= C_IDLE;
            hold_cnt_q <= '0;
            number_q   <= '0;
            control_q  <= 1'b0;
            value_q    <= 1'b0;
        end else begin
            if (w_is_value) value_q <= byte_q[0];
            case (seq_q)
                C_IDLE: begin
                    if (w_accept) begin
                        number_q <= byte_q[3:0];
                        seq_q    <= C_SETUP;
                    end
                end
                C_SETUP: begin
                    seq_q      <= C_HIGH;
                    control_q  <= 1'b1;
                    hold_cnt_q <= '0;
                end
                C_HIGH: begin
                    if (hold_cnt_q == C_HOLD_LAST) begin
                        seq_q      <= C_LOW;
                        control_q  <= 1'b0;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                C_LOW: begin
                    if (hold_cnt_q == C_HOLD_LAST) seq_q <= C_IDLE;
                    else hold_cnt_q <= hold_cnt_q + 8'd1;
                end
                default: seq_q <= C_IDLE;
            endcase
        end
    end

    assign number      = number_q;
    assign control     = control_q;
    assign value       = value_q;
    assign frame_error = ferr_q;
    assign cmd_error   = byte_vld_q && !(w_accept || w_is_value);
    assign busy        = (rx_state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_cmd_rx                                                           |
// | Directed and random command traffic into two receivers (short and long   |
// | control hold) checked against a byte-level behavioural model.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_cmd_rx;
    localparam int BAUD     = 100_000;
    localparam int CLK_FREQ = 1_600_000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int HOLD_A   = 4;
    localparam int HOLD_B   = 255;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic [3:0] num_w  [2];
    logic       ctl_w  [2];
    logic       val_w  [2];
    logic       ferr_w [2];
    logic       cerr_w [2];
    logic       busy_w [2];

    always #5 clk = ~clk;

    uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .CTRL_HOLD(HOLD_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .rx(rx),
        .number(num_w[0]), .control(ctl_w[0]), .value(val_w[0]),
        .frame_error(ferr_w[0]), .cmd_error(cerr_w[0]), .busy(busy_w[0])
    );

    uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .CTRL_HOLD(HOLD_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .rx(rx),
        .number(num_w[1]), .control(ctl_w[1]), .value(val_w[1]),
        .frame_error(ferr_w[1]), .cmd_error(cerr_w[1]), .busy(busy_w[1])
    );

    // Output observation, one sample per cycle on the falling edge
    int         cyc = 0;
    int         rises [2]     = '{0, 0};
    int         cerr_cnt [2]  = '{0, 0};
    int         ferr_cnt [2]  = '{0, 0};
    int         width_err [2] = '{0, 0};
    int         stab_err [2]  = '{0, 0};
    int         hi_len [2]    = '{0, 0};
    int         last_hi [2]   = '{0, 0};
    int         busy_run [2]  = '{0, 0};
    int         last_busy [2] = '{0, 0};
    int         rise_cyc [2]  = '{0, 0};
    int         chg_cyc [2]   = '{0, 0};
    logic [3:0] rise_num [2]  = '{4'h0, 4'h0};
    logic [3:0] prev_num [2]  = '{4'h0, 4'h0};
    logic       prev_ctl [2]  = '{1'b0, 1'b0};
    logic       prev_busy [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (num_w[i] !== prev_num[i]) chg_cyc[i] = cyc;
            if (prev_ctl[i] && (num_w[i] !== prev_num[i])) stab_err[i]++;
            if (ctl_w[i] && !prev_ctl[i]) begin
                rises[i]++;
                rise_cyc[i] = cyc;
                rise_num[i] = num_w[i];
                if (num_w[i] !== prev_num[i]) stab_err[i]++;
                hi_len[i] = 0;
            end
            if (ctl_w[i]) hi_len[i]++;
            if (!ctl_w[i] && prev_ctl[i]) begin
                last_hi[i] = hi_len[i];
                if (hi_len[i] != ((i == 0) ? HOLD_A : HOLD_B)) width_err[i]++;
            end
            if (cerr_w[i]) cerr_cnt[i]++;
            if (ferr_w[i]) ferr_cnt[i]++;
            if (busy_w[i]) busy_run[i]++;
            if (!busy_w[i] && prev_busy[i]) last_busy[i] = busy_run[i];
            if (!busy_w[i]) busy_run[i] = 0;
            prev_num[i]  = num_w[i];
            prev_ctl[i]  = ctl_w[i];
            prev_busy[i] = busy_w[i];
        end
    end

    // Behavioural model: outcome of each byte, keyed by the cycle its start bit began
    logic [3:0] exp_num [2]   = '{4'h0, 4'h0};
    logic [3:0] exp_rnum [2]  = '{4'h0, 4'h0};
    int         exp_rises [2] = '{0, 0};
    int         exp_cerr [2]  = '{0, 0};
    int         last_acc [2]  = '{-100000, -100000};
    int         exp_ferr      = 0;
    logic       exp_val       = 1'b0;

    task automatic model_byte(input logic [7:0] b, input int t_start, input bit ok);
        int hold;
        if (!ok) begin
            exp_ferr++;
        end else if (b[7:4] == 4'h5) begin
            for (int i = 0; i < 2; i++) begin
                hold = (i == 0) ? HOLD_A : HOLD_B;
                if (t_start - last_acc[i] >= 2 + 2 * hold) begin
                    exp_num[i]  = b[3:0];
                    exp_rnum[i] = b[3:0];
                    exp_rises[i]++;
                    last_acc[i] = t_start;
                end else begin
                    exp_cerr[i]++;
                end
            end
        end else if (b[7:4] == 4'h6) begin
            exp_val = b[0];
        end else begin
            exp_cerr[0]++;
            exp_cerr[1]++;
        end
    endtask

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s number[%0d]", tag, i), 32'(num_w[i]), 32'(exp_num[i]));
            check($sformatf("%s value[%0d]", tag, i), 32'(val_w[i]), 32'(exp_val));
            check($sformatf("%s rises[%0d]", tag, i), rises[i], exp_rises[i]);
            check($sformatf("%s rise_num[%0d]", tag, i), 32'(rise_num[i]), 32'(exp_rnum[i]));
            check($sformatf("%s cmd_err[%0d]", tag, i), cerr_cnt[i], exp_cerr[i]);
            check($sformatf("%s frame_err[%0d]", tag, i), ferr_cnt[i], exp_ferr);
            check($sformatf("%s width_err[%0d]", tag, i), width_err[i], 0);
            check($sformatf("%s stab_err[%0d]", tag, i), stab_err[i], 0);
            check($sformatf("%s busy[%0d]", tag, i), 32'(busy_w[i]), 0);
            check($sformatf("%s control[%0d]", tag, i), 32'(ctl_w[i]), 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic v);
        rx = v;
        idle(DIV);
    endtask

    // Leaves rx low after the frame when stop_ok is 0
    task automatic send(input logic [7:0] b, input bit stop_ok);
        model_byte(b, cyc, stop_ok);
        put_bit(1'b0);
        for (int i = 0; i < 8; i++) put_bit(b[i]);
`ifdef UART_CMD_PARITY_EN
        put_bit(^b);
`endif
        put_bit(stop_ok);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         kind;
        int         gap;

        idle(5);
        reset_n = 1'b1;
        idle(20);
        check_all("reset");

        send(8'h53, 1'b1);
        idle(600);
        check("t53 rise-after-number", rise_cyc[0] - chg_cyc[0], 1);
        check("t53 high-cycles", last_hi[0], HOLD_A);
        check_all("t53");

        send(8'h61, 1'b1);
        idle(50);
        check_all("t61");
        send(8'h60, 1'b1);
        idle(600);
        check_all("t60");

        send(8'h5A, 1'b0);
        idle(3 * DIV);
        check("ferr busy-held[0]", 32'(busy_w[0]), 1);
        check("ferr busy-held[1]", 32'(busy_w[1]), 1);
        rx = 1'b1;
        idle(5);
        check_all("ferr");

        rx = 1'b0;
        idle(DIV / 4);
        rx = 1'b1;
        idle(40);
        for (int i = 0; i < 2; i++)
            check($sformatf("glitch busy-len-ok[%0d]", i),
                  32'((last_busy[i] > 0) && (last_busy[i] < DIV / 2 + 2)), 1);
        check_all("glitch");

        send(8'h52, 1'b1);
        send(8'h5F, 1'b1);
        idle(600);
        check_all("drop");

        send(8'h7F, 1'b1);
        idle(30);
        check_all("t7f");

        put_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            b = 8'h55;
            put_bit(b[i]);
        end
        reset_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("inreset number[%0d]", i), 32'(num_w[i]), 0);
            check($sformatf("inreset control[%0d]", i), 32'(ctl_w[i]), 0);
            check($sformatf("inreset value[%0d]", i), 32'(val_w[i]), 0);
            check($sformatf("inreset frame_error[%0d]", i), 32'(ferr_w[i]), 0);
            check($sformatf("inreset cmd_error[%0d]", i), 32'(cerr_w[i]), 0);
            check($sformatf("inreset busy[%0d]", i), 32'(busy_w[i]), 0);
        end
        rx = 1'b1;
        idle(40);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_num[i]  = 4'h0;
            last_acc[i] = -100000;
        end
        exp_val = 1'b0;
        idle(20);
        check_all("post-reset");
        send(8'h55, 1'b1);
        idle(600);
        check_all("t55");

        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 3 || kind == 9) begin
                b = {4'h5, 4'($urandom_range(0, 15))};
            end else if (kind <= 5) begin
                b = {4'h6, 4'($urandom_range(0, 15))};
            end else begin
                b = 8'($urandom_range(0, 255));
                while (b[7:4] == 4'h5 || b[7:4] == 4'h6) b = 8'($urandom_range(0, 255));
            end
            gap = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(620, 700));
            if (kind == 8) begin
                send(b, 1'b0);
                rx = 1'b1;
                if (gap < DIV) gap = DIV;
            end else begin
                send(b, 1'b1);
            end
            idle(gap);
            if (gap >= 600) check_all($sformatf("rand%0d", n));
        end
        idle(600);
        check_all("rand-end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
